// File: rtl/l0_ctrl_pkg.sv
// Shared constants and state encoding for the L0 input-buffer sequencer.
package l0_ctrl_pkg;
  localparam int ROW_DEF   = 8;
  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 11;
  localparam int CW_DEF    = 7;
  localparam int STALL_W   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/l0_ctrl_rd_skew.sv
// Diagonal read skew for the L0 rows: row i reads i ready-steps after row 0.
module l0_rd_skew #(
  parameter int ROW = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           step,
  input  logic           issue,
  output logic [ROW-1:0] l0_rd,
  output logic           tail_empty
);
  logic [ROW-1:0] pipe_q, pipe_d, shifted;

  assign shifted = {pipe_q[ROW-2:0], issue};

  // The pipe only advances on a ready step and is flushed whenever drain is not active.
  always_comb begin
    pipe_d = pipe_q;
    l0_rd  = '0;
    if (!en) begin
      pipe_d = '0;
    end else if (step) begin
      pipe_d = shifted;
      l0_rd  = shifted;
    end
  end

  // Nothing left below the last row once this step has been taken.
  assign tail_empty = (shifted[ROW-2:0] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe_q <= '0;
    else          pipe_q <= pipe_d;
  end
endmodule

// File: rtl/l0_ctrl.sv
// L0 input-buffer sequencer: loads N vectors from SRAM into all rows, then drains with a skew.
// Optional DRAIN stall counter enabled by defining L0_CTRL_STALL_CNT_EN.
module l0_ctrl
  import l0_ctrl_pkg::*;
#(
  parameter int ROW   = ROW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [AW-1:0]      base_addr,
  input  logic [CW-1:0]      num_vec,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               sram_ren,
  output logic [AW-1:0]      sram_addr,
  output logic               l0_wr,
  input  logic               l0_full,
  input  logic [ROW-1:0]     l0_empty,
  output logic [ROW-1:0]     l0_rd,
  input  logic               array_ready,
  output logic [STALL_W-1:0] stall_cycles,
  output logic [1:0]         dbg_state
);
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] n_q, n_d, cnt_q, cnt_d, n_sat;
  logic          err_q, err_d, wr_q;
  logic          issue, tail_empty;

  assign n_sat     = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign sram_ren  = (state_q == ST_LOAD) && (cnt_q != n_q);
  assign issue     = (state_q == ST_DRAIN) && (cnt_q != n_q);
  assign sram_addr = sram_ren ? (base_q + AW'(cnt_q)) : '0;
  assign l0_wr     = wr_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign dbg_state = state_q;

  // cnt counts SRAM reads in LOAD and wavefront issues in DRAIN.
  // A zero-length tile spends one cycle in LOAD before DONE.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          n_d     = n_sat;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (sram_ren) begin
          cnt_d = cnt_q + 1'b1;
        end else if (n_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (array_ready && issue) cnt_d = cnt_q + 1'b1;
        if (array_ready && !issue && tail_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_q && l0_full) err_d = 1'b1;
    if (|(l0_rd & l0_empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_q    <= sram_ren;
    end
  end

  // Handshake: array_ready=1 means the array accepts one wavefront step this cycle;
  // l0_rd is only asserted in such a cycle, otherwise the skew pipe holds.
  l0_rd_skew #(.ROW(ROW)) u_skew (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (state_q == ST_DRAIN),
    .step       (array_ready),
    .issue      (issue),
    .l0_rd      (l0_rd),
    .tail_empty (tail_empty)
  );

`ifdef L0_CTRL_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) stall_d = '0;
    else if (state_q == ST_DRAIN && !array_ready && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_l0_ctrl.sv
// Scoreboard bench for l0_ctrl: a tile-level model predicts SRAM reads, L0 writes, skewed reads and done.
module tb_l0_ctrl;
  localparam int ROW  = 8;
  localparam int AW   = 11;
  localparam int CW   = 7;
  localparam int MAXT = 400;

  logic           clk = 1'b0;
  logic           reset_n, start, l0_full, array_ready;
  logic [AW-1:0]  base_addr;
  logic [CW-1:0]  num_vec;
  logic           busy, done, err, sram_ren, l0_wr;
  logic [AW-1:0]  sram_addr;
  logic [ROW-1:0] l0_empty, l0_rd;
  logic [15:0]    stall_cycles;
  logic [1:0]     dbg_state;
  logic [19:0]    cyc = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [31:0] exp_ren_q[$];
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_done_q[$];

  bit             rdy_a[MAXT];
  bit             full_a[MAXT];
  logic [ROW-1:0] empty_a[MAXT];

  l0_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .err(err), .sram_ren(sram_ren), .sram_addr(sram_addr),
    .l0_wr(l0_wr), .l0_full(l0_full), .l0_empty(l0_empty), .l0_rd(l0_rd),
    .array_ready(array_ready), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected assertion at cycle %0d", name, cyc);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, {26'b0, busy, done, err, sram_ren, l0_wr, dbg_state}, 32'h0);
    chk({name, "_rd"}, {24'b0, l0_rd}, 32'h0);
    chk({name, "_addr"}, {21'b0, sram_addr}, 32'h0);
    chk({name, "_stall"}, {16'b0, stall_cycles}, 32'h0);
  endtask

  // Monitor: pops one expected event per observed DUT output assertion.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sram_ren) begin
        if (exp_ren_q.size() == 0) unexp("sram_ren");
        else chk("sram_ren", {1'b0, cyc, sram_addr}, exp_ren_q.pop_front());
      end
      if (l0_wr) begin
        if (exp_wr_q.size() == 0) unexp("l0_wr");
        else chk("l0_wr", {12'b0, cyc}, exp_wr_q.pop_front());
      end
      for (int i = 0; i < ROW; i++) begin
        if (l0_rd[i]) begin
          if (exp_rd_q.size() == 0) unexp("l0_rd");
          else chk("l0_rd", {9'b0, cyc, 3'(i)}, exp_rd_q.pop_front());
        end
      end
      if (done) begin
        chk("busy_at_done", {31'b0, busy}, 32'h0);
        if (exp_done_q.size() == 0) unexp("done");
        else chk("done", {12'b0, cyc}, exp_done_q.pop_front());
      end
    end
  end

  // rdy_mode: 0 always ready, 1 not ready in cycles 8..10, 2 random stalls.
  task automatic run_tile(input int n_in, input int base, input int rdy_mode,
                          input bit force_e3, input bit rnd_err, input bit spam, input int abort_t);
    int          n, t_done, stalls, exp_stall, k;
    bit          exp_err;
    int          rt[$];
    logic [19:0] c0;
    n = (n_in > 64) ? 64 : n_in;
    for (int t = 0; t < MAXT; t++) begin
      case (rdy_mode)
        0:       rdy_a[t] = 1'b1;
        1:       rdy_a[t] = !(t >= 8 && t <= 10);
        default: rdy_a[t] = (t >= 300) || ($urandom_range(0, 3) != 0);
      endcase
      full_a[t] = rnd_err && ($urandom_range(0, 7) == 0);
      empty_a[t] = '0;
      for (int r = 0; r < ROW; r++) empty_a[t][r] = rnd_err && ($urandom_range(0, 15) == 0);
      if (force_e3 && t >= n + 2) empty_a[t][3] = 1'b1;
    end

    @(posedge clk);
    #1;
    c0 = cyc;
    exp_err = 1'b0;
    stalls = 0;
    if (n == 0) begin
      t_done = 2;
    end else begin
      for (int j = 0; j < n; j++) begin
        exp_ren_q.push_back({1'b0, 20'(c0 + 20'(1 + j)), 11'(base + j)});
        exp_wr_q.push_back({12'b0, 20'(c0 + 20'(2 + j))});
        if (full_a[2 + j]) exp_err = 1'b1;
      end
      for (int t = n + 2; t < MAXT && rt.size() < n + ROW - 1; t++) begin
        if (rdy_a[t]) rt.push_back(t);
        else stalls++;
      end
      // Row i takes its k-th vector on ready step k+i of the drain.
      for (int j = 0; j < rt.size(); j++) begin
        for (int r = 0; r < ROW; r++) begin
          k = j - r;
          if (k >= 0 && k < n) begin
            exp_rd_q.push_back({9'b0, 20'(c0 + 20'(rt[j])), 3'(r)});
            if (empty_a[rt[j]][r]) exp_err = 1'b1;
          end
        end
      end
      t_done = rt[rt.size() - 1] + 1;
    end
    exp_done_q.push_back({12'b0, 20'(c0 + 20'(t_done))});
`ifdef L0_CTRL_STALL_CNT_EN
    exp_stall = stalls;
`else
    exp_stall = 0;
`endif

    start = 1'b1;
    base_addr = AW'(base);
    num_vec = CW'(n_in);
    array_ready = rdy_a[0];
    l0_full = full_a[0];
    l0_empty = empty_a[0];
    for (int t = 1; t <= t_done + 1; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (spam && n > 0 && t == 3) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        num_vec = CW'($urandom_range(0, 100));
      end
      array_ready = rdy_a[t];
      l0_full = full_a[t];
      l0_empty = empty_a[t];
      if (t == 1) begin
        chk("err_cleared", {31'b0, err}, 32'h0);
        chk("stall_cleared", {16'b0, stall_cycles}, 32'h0);
      end
      if (t == abort_t) begin
        #2;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        exp_ren_q.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_done_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en = 1'b1;
        return;
      end
    end
    chk("err_final", {31'b0, err}, {31'b0, exp_err});
    chk("stall_final", {16'b0, stall_cycles}, 32'(exp_stall));
    chk("queues_drained", 32'(exp_ren_q.size() + exp_wr_q.size() + exp_rd_q.size() + exp_done_q.size()), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_vec = '0;
    l0_full = 1'b0;
    l0_empty = '0;
    array_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;

    run_tile(4, 'h100, 0, 1'b0, 1'b0, 1'b0, 0);
    run_tile(4, 'h100, 1, 1'b0, 1'b0, 1'b0, 0);
    run_tile(0, 'h055, 0, 1'b0, 1'b0, 1'b0, 0);
    run_tile(100, 'h7f0, 0, 1'b0, 1'b0, 1'b0, 0);
    run_tile(8, 'h200, 0, 1'b0, 1'b0, 1'b0, 13);
    run_tile(2, 'h010, 0, 1'b0, 1'b0, 1'b0, 0);
    run_tile(4, 'h300, 0, 1'b1, 1'b0, 1'b1, 0);
    run_tile(3, 'h020, 0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      run_tile($urandom_range(0, 80), $urandom_range(0, 2047), 2, 1'b0, 1'b1,
               1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
